// File: rtl/mips_single_cycle_pkg.sv
// Shared definitions for the single-cycle MIPS core: opcode/funct encodings,
// control word layout, instruction decoder and ALU helper functions.
package mips_single_cycle_pkg;

  localparam int REG_COUNT = 32;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JUMP, PC_JR} pc_sel_e;

  typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} dst_sel_e;

  typedef struct packed {
    logic     reg_we;
    dst_sel_e dst;
    logic     alu_imm;
    logic     imm_zext;
    alu_op_e  alu_op;
    logic     mem_we;
    logic     mem_to_reg;
    logic     link;
    pc_sel_e  pc_sel;
    logic     branch_ne;
  } ctrl_t;

  // Unrecognised opcodes and functs fall through with every enable cleared (NOP).
  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode, input logic [5:0] funct);
    ctrl_t c;
    c.reg_we     = 1'b0;
    c.dst        = DST_RT;
    c.alu_imm    = 1'b0;
    c.imm_zext   = 1'b0;
    c.alu_op     = ALU_ADD;
    c.mem_we     = 1'b0;
    c.mem_to_reg = 1'b0;
    c.link       = 1'b0;
    c.pc_sel     = PC_SEQ;
    c.branch_ne  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        c.reg_we = 1'b1;
        c.dst    = DST_RD;
        case (funct)
          FN_ADD, FN_ADDU: c.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_XOR:  c.alu_op = ALU_XOR;
          FN_NOR:  c.alu_op = ALU_NOR;
          FN_SLT:  c.alu_op = ALU_SLT;
          FN_SLTU: c.alu_op = ALU_SLTU;
          FN_SLL:  c.alu_op = ALU_SLL;
          FN_SRL:  c.alu_op = ALU_SRL;
          FN_SRA:  c.alu_op = ALU_SRA;
          FN_JR: begin
            c.reg_we = 1'b0;
            c.pc_sel = PC_JR;
          end
          default: c.reg_we = 1'b0;
        endcase
      end
      OP_J: c.pc_sel = PC_JUMP;
      OP_JAL: begin
        c.pc_sel = PC_JUMP;
        c.reg_we = 1'b1;
        c.dst    = DST_RA;
        c.link   = 1'b1;
      end
      OP_BEQ: c.pc_sel = PC_BRANCH;
      OP_BNE: begin
        c.pc_sel    = PC_BRANCH;
        c.branch_ne = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin
        c.reg_we  = 1'b1;
        c.alu_imm = 1'b1;
      end
      OP_SLTI: begin
        c.reg_we  = 1'b1;
        c.alu_imm = 1'b1;
        c.alu_op  = ALU_SLT;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        c.reg_we   = 1'b1;
        c.alu_imm  = 1'b1;
        c.imm_zext = 1'b1;
        case (opcode)
          OP_ANDI: c.alu_op = ALU_AND;
          OP_ORI:  c.alu_op = ALU_OR;
          OP_XORI: c.alu_op = ALU_XOR;
          default: c.alu_op = ALU_LUI;
        endcase
      end
      OP_LW: begin
        c.reg_we     = 1'b1;
        c.alu_imm    = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        c.alu_imm = 1'b1;
        c.mem_we  = 1'b1;
      end
      default: c.reg_we = 1'b0;
    endcase
    return c;
  endfunction

  // Shifts operate on the second operand (rt) by shamt, as MIPS encodes them.
  function automatic logic [31:0] alu_calc(input alu_op_e op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] shamt);
    logic [31:0] y;
    y = 32'd0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOR:  y = ~(a | b);
      ALU_SLT:  y = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {31'd0, (a < b)};
      ALU_SLL:  y = b << shamt;
      ALU_SRL:  y = b >> shamt;
      ALU_SRA:  y = $unsigned($signed(b) >>> shamt);
      ALU_LUI:  y = {b[15:0], 16'h0000};
      default:  y = 32'd0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one write port on the
// rising edge; $0 reads as zero and ignores writes.
module mips_regfile
  import mips_single_cycle_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);
  logic [31:0] r_regs [REG_COUNT];

  // Reset clears every register and wins over a same-cycle write.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (i_we && (i_wa != 5'd0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : r_regs[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : r_regs[i_ra2];

endmodule

// File: rtl/mips_single_cycle.sv
// Single-cycle MIPS core with word-addressed instruction memory and a
// big-endian byte-addressed data memory; every instruction retires per clock.
module mips_single_cycle
  import mips_single_cycle_pkg::*;
#(
  parameter int    IMEM_WORDS = 256,
  parameter int    DMEM_BYTES = 1024,
  parameter string IMEM_INIT  = "Machine-Code.txt"
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] dbg_pc,
  output logic [31:0] dbg_instr
);
  localparam int IMEM_AW = $clog2(IMEM_WORDS);
  localparam int DMEM_AW = $clog2(DMEM_BYTES);

  logic [31:0] r_pc;
  logic [31:0] r_imem [IMEM_WORDS];
  logic [7:0]  r_dmem [DMEM_BYTES];

  logic              w_imem_hit;
  logic [31:0]       w_instr;
  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;
  logic [4:0]        w_shamt;
  logic [15:0]       w_imm;
  logic [25:0]       w_target;
  ctrl_t             w_ctrl;
  logic [31:0]       w_rd1;
  logic [31:0]       w_rd2;
  logic [31:0]       w_imm_ext;
  logic [31:0]       w_alu_b;
  logic [31:0]       w_alu_y;
  logic [31:0]       w_pc4;
  logic [31:0]       w_next_pc;
  logic              w_br_taken;
  logic [DMEM_AW-3:0] w_dword;
  logic [31:0]       w_mem_rdata;
  logic [4:0]        w_waddr;
  logic [31:0]       w_wdata;

  // Word addresses past the end of instruction memory fetch a NOP.
  assign w_imem_hit = (r_pc[31:IMEM_AW+2] == {(30-IMEM_AW){1'b0}});
  assign w_instr    = w_imem_hit ? r_imem[r_pc[IMEM_AW+1:2]] : 32'd0;

  assign w_opcode = w_instr[31:26];
  assign w_rs     = w_instr[25:21];
  assign w_rt     = w_instr[20:16];
  assign w_rd     = w_instr[15:11];
  assign w_shamt  = w_instr[10:6];
  assign w_funct  = w_instr[5:0];
  assign w_imm    = w_instr[15:0];
  assign w_target = w_instr[25:0];

  assign w_ctrl    = decode_ctrl(w_opcode, w_funct);
  assign w_imm_ext = w_ctrl.imm_zext ? {16'h0000, w_imm} : {{16{w_imm[15]}}, w_imm};
  assign w_alu_b   = w_ctrl.alu_imm ? w_imm_ext : w_rd2;
  assign w_alu_y   = alu_calc(w_ctrl.alu_op, w_rd1, w_alu_b, w_shamt);
  assign w_pc4     = r_pc + 32'd4;

  mips_regfile u_regfile (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_we    (w_ctrl.reg_we),
    .i_wa    (w_waddr),
    .i_wd    (w_wdata),
    .i_ra1   (w_rs),
    .i_ra2   (w_rt),
    .o_rd1   (w_rd1),
    .o_rd2   (w_rd2)
  );

  // Data memory is addressed per word; the byte offset bits are dropped and
  // upper address bits wrap naturally by truncation.
  assign w_dword     = w_alu_y[DMEM_AW-1:2];
  assign w_mem_rdata = {r_dmem[{w_dword, 2'b00}], r_dmem[{w_dword, 2'b01}],
                        r_dmem[{w_dword, 2'b10}], r_dmem[{w_dword, 2'b11}]};

  // Store path; memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_ctrl.mem_we) begin
      r_dmem[{w_dword, 2'b00}] <= w_rd2[31:24];
      r_dmem[{w_dword, 2'b01}] <= w_rd2[23:16];
      r_dmem[{w_dword, 2'b10}] <= w_rd2[15:8];
      r_dmem[{w_dword, 2'b11}] <= w_rd2[7:0];
    end
  end

  // Writeback destination and data selection.
  always_comb begin
    w_waddr = w_rt;
    w_wdata = w_alu_y;
    case (w_ctrl.dst)
      DST_RD:  w_waddr = w_rd;
      DST_RA:  w_waddr = 5'd31;
      default: w_waddr = w_rt;
    endcase
    if (w_ctrl.link) begin
      w_wdata = w_pc4;
    end else if (w_ctrl.mem_to_reg) begin
      w_wdata = w_mem_rdata;
    end else begin
      w_wdata = w_alu_y;
    end
  end

  // Next-PC selection.
  always_comb begin
    w_next_pc  = w_pc4;
    w_br_taken = w_ctrl.branch_ne ? (w_rd1 != w_rd2) : (w_rd1 == w_rd2);
    case (w_ctrl.pc_sel)
      PC_BRANCH: begin
        if (w_br_taken) begin
          w_next_pc = w_pc4 + {w_imm_ext[29:0], 2'b00};
        end else begin
          w_next_pc = w_pc4;
        end
      end
      PC_JUMP: w_next_pc = {w_pc4[31:28], w_target, 2'b00};
      PC_JR:   w_next_pc = w_rd1;
      default: w_next_pc = w_pc4;
    endcase
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= 32'd0;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  assign dbg_pc    = r_pc;
  assign dbg_instr = w_instr;

endmodule

// File: tb/tb_mips_single_cycle.sv
// Directed and random programs run in lockstep against an ISA-level interpreter.
module tb_mips_single_cycle;
  localparam int IMW = 256;
  localparam int DMB = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dbg_pc;
  logic [31:0] dbg_instr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_imem [IMW];
  logic [31:0] m_regs [32];
  logic [7:0]  m_mem  [DMB];
  logic [31:0] m_pc;
  logic [31:0] prog [$];

  mips_single_cycle #(.IMEM_WORDS(IMW), .DMEM_BYTES(DMB), .IMEM_INIT("Machine-Code.txt")) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dbg_pc    (dbg_pc),
    .dbg_instr (dbg_instr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int fn, input int rs, input int rt, input int rd, input int sh);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(input int op, input int target);
    return {6'(op), 26'(target)};
  endfunction

  function automatic logic [31:0] rf(input int i);
    return dut.u_regfile.r_regs[i];
  endfunction
  function automatic logic [31:0] dword(input int w);
    return {dut.r_dmem[4*w], dut.r_dmem[4*w+1], dut.r_dmem[4*w+2], dut.r_dmem[4*w+3]};
  endfunction
  function automatic logic [31:0] m_word(input int w);
    return {m_mem[4*w], m_mem[4*w+1], m_mem[4*w+2], m_mem[4*w+3]};
  endfunction
  function automatic logic [31:0] m_fetch(input logic [31:0] pc);
    if (pc[31:10] == 22'd0) return m_imem[pc[9:2]];
    return 32'd0;
  endfunction

  // Reference interpreter: executes one instruction on the model state.
  task automatic m_step();
    logic [31:0] ins, a, b, simm, zimm, npc, wv, ea;
    logic [4:0]  dst, sh;
    logic        wr;
    ins  = m_fetch(m_pc);
    a    = m_regs[ins[25:21]];
    b    = m_regs[ins[20:16]];
    sh   = ins[10:6];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'd0, ins[15:0]};
    npc  = m_pc + 32'd4;
    ea   = a + simm;
    wr   = 1'b1;
    dst  = ins[20:16];
    wv   = 32'd0;
    case (ins[31:26])
      6'd0: begin
        dst = ins[15:11];
        case (ins[5:0])
          6'h20, 6'h21: wv = a + b;
          6'h22, 6'h23: wv = a - b;
          6'h24: wv = a & b;
          6'h25: wv = a | b;
          6'h26: wv = a ^ b;
          6'h27: wv = ~(a | b);
          6'h2A: wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: wv = (a < b) ? 32'd1 : 32'd0;
          6'h00: wv = b << sh;
          6'h02: wv = b >> sh;
          6'h03: wv = $signed(b) >>> sh;
          6'h08: begin wr = 1'b0; npc = a; end
          default: wr = 1'b0;
        endcase
      end
      6'd2: begin wr = 1'b0; npc = {npc[31:28], ins[25:0], 2'b00}; end
      6'd3: begin dst = 5'd31; wv = npc; npc = {npc[31:28], ins[25:0], 2'b00}; end
      6'd4: begin wr = 1'b0; if (a == b) npc = npc + (simm << 2); end
      6'd5: begin wr = 1'b0; if (a != b) npc = npc + (simm << 2); end
      6'd8, 6'd9: wv = a + simm;
      6'd10: wv = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0;
      6'd12: wv = a & zimm;
      6'd13: wv = a | zimm;
      6'd14: wv = a ^ zimm;
      6'd15: wv = {ins[15:0], 16'd0};
      6'd35: wv = {m_mem[{ea[9:2], 2'd0}], m_mem[{ea[9:2], 2'd1}], m_mem[{ea[9:2], 2'd2}], m_mem[{ea[9:2], 2'd3}]};
      6'd43: begin
        wr = 1'b0;
        m_mem[{ea[9:2], 2'd0}] = b[31:24];
        m_mem[{ea[9:2], 2'd1}] = b[23:16];
        m_mem[{ea[9:2], 2'd2}] = b[15:8];
        m_mem[{ea[9:2], 2'd3}] = b[7:0];
      end
      default: wr = 1'b0;
    endcase
    if (wr && dst != 5'd0) m_regs[dst] = wv;
    m_pc = npc;
  endtask

  task automatic load_prog();
    for (int i = 0; i < IMW; i++) begin
      m_imem[i] = (i < prog.size()) ? prog[i] : 32'd0;
      dut.r_imem[i] = m_imem[i];
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DMB; i++) begin
      m_mem[i] = 8'd0;
      dut.r_dmem[i] = 8'd0;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      check("instr", dbg_instr, m_fetch(m_pc));
      m_step();
      @(posedge clk);
      #1;
      check("pc", dbg_pc, m_pc);
    end
  endtask

  task automatic compare_state(input string tag);
    for (int i = 0; i < 32; i++) check({tag, "_reg"}, rf(i), m_regs[i]);
    for (int w = 0; w < DMB / 4; w++) check({tag, "_mem"}, dword(w), m_word(w));
  endtask

  function automatic logic [31:0] rand_instr();
    int unsigned k;
    int rs, rt, rd, imm;
    logic [5:0] fns [10];
    logic [5:0] shf [3];
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    shf = '{6'h00, 6'h02, 6'h03};
    k   = $urandom_range(0, 12);
    rs  = int'($urandom_range(0, 15));
    rt  = int'($urandom_range(0, 15));
    rd  = int'($urandom_range(0, 15));
    imm = int'($urandom_range(0, 65535));
    case (k)
      0: return enc_i(8, rs, rt, imm);
      1: return enc_i(9, rs, rt, imm);
      2: return enc_i(10, rs, rt, imm);
      3: return enc_i(12, rs, rt, imm);
      4: return enc_i(13, rs, rt, imm);
      5: return enc_i(14, rs, rt, imm);
      6: return enc_i(15, 0, rt, imm);
      7: return enc_r(int'(fns[$urandom_range(0, 9)]), rs, rt, rd, 0);
      8: return enc_r(int'(shf[$urandom_range(0, 2)]), 0, rt, rd, int'($urandom_range(0, 31)));
      9: return enc_i(35, rs, rt, imm);
      10: return enc_i(43, rs, rt, imm);
      11: return enc_i(63, rs, rt, imm);
      default: return enc_r(63, rs, rt, rd, 0);
    endcase
  endfunction

  initial begin
    logic [31:0] trace [9];
    clear_mem();

    // Reset and straight-line NOPs
    prog = {};
    load_prog();
    do_reset(2);
    check("rst_pc", dbg_pc, 32'd0);
    for (int i = 0; i < 32; i++) check("rst_reg", rf(i), 32'd0);
    run(3);
    check("nop_pc", dbg_pc, 32'h0000000C);

    // ALU sequence
    prog = {enc_i(8, 0, 8, 5), enc_i(8, 0, 9, -3), enc_r(32, 8, 9, 10, 0),
            enc_r(42, 9, 8, 11, 0), enc_r(0, 0, 8, 12, 2), enc_i(8, 0, 0, 7), enc_j(2, 6)};
    load_prog();
    do_reset(2);
    run(8);
    check("alu_add", rf(10), 32'd2);
    check("alu_slt", rf(11), 32'd1);
    check("alu_sll", rf(12), 32'h14);
    check("alu_r0", rf(0), 32'd0);
    check("alu_halt", dbg_pc, 32'h18);
    compare_state("alu");

    // Big-endian store and load
    prog = {enc_i(15, 0, 8, 16'h1234), enc_i(13, 8, 8, 16'h5678), enc_i(43, 0, 8, 4),
            enc_i(35, 0, 9, 4), enc_j(2, 4)};
    load_prog();
    do_reset(2);
    run(6);
    check("mem_lw", rf(9), 32'h12345678);
    check("mem_b4", {24'd0, dut.r_dmem[4]}, 32'h12);
    check("mem_b5", {24'd0, dut.r_dmem[5]}, 32'h34);
    check("mem_b6", {24'd0, dut.r_dmem[6]}, 32'h56);
    check("mem_b7", {24'd0, dut.r_dmem[7]}, 32'h78);
    compare_state("mem");

    // Squares loop: beq exit, j back-edge, bne fall-through, self-jump halt
    prog = {enc_i(8, 0, 8, 0), enc_i(8, 0, 9, 0), enc_i(8, 0, 10, 1), enc_i(8, 0, 11, 0),
            enc_i(8, 0, 12, 12), enc_i(4, 8, 12, 6), enc_i(43, 11, 9, 0), enc_r(32, 9, 10, 9, 0),
            enc_i(8, 10, 10, 2), enc_i(8, 11, 11, 4), enc_i(8, 8, 8, 1), enc_j(2, 5),
            enc_i(5, 8, 12, -8), enc_j(2, 13)};
    clear_mem();
    load_prog();
    do_reset(2);
    run(100);
    check("fill_halt", dbg_pc, 32'h34);
    for (int k = 0; k < 12; k++) check("fill_word", dword(k), 32'(k * k));
    compare_state("fill");

    // Reset on the cycle a store is pending
    clear_mem();
    do_reset(2);
    run(27);
    check("mid_instr", dbg_instr, enc_i(43, 11, 9, 0));
    do_reset(1);
    check("mid_pc", dbg_pc, 32'd0);
    for (int i = 0; i < 32; i++) check("mid_reg", rf(i), 32'd0);
    check("mid_w2", dword(2), 32'd4);
    check("mid_w3", dword(3), 32'd0);
    compare_state("mid");
    run(5);

    // Branch/jump trace with jal/jr round trip
    prog = {enc_i(8, 0, 8, 1), enc_i(8, 0, 9, 1), enc_i(4, 8, 9, 1), enc_i(8, 0, 10, 99),
            enc_i(5, 8, 9, 5), enc_j(3, 8), enc_i(8, 0, 11, 7), enc_j(2, 7),
            enc_i(8, 0, 12, 42), enc_r(8, 31, 0, 0, 0)};
    trace = '{32'h04, 32'h08, 32'h10, 32'h14, 32'h20, 32'h24, 32'h18, 32'h1C, 32'h1C};
    load_prog();
    do_reset(2);
    for (int i = 0; i < 9; i++) begin
      run(1);
      check("br_trace", dbg_pc, trace[i]);
    end
    check("br_skip", rf(10), 32'd0);
    check("br_ra", rf(31), 32'h18);
    check("br_ret", rf(11), 32'd7);
    check("br_sub", rf(12), 32'd42);

    // Fetch past the end of instruction memory returns NOPs
    prog = {enc_i(8, 0, 8, 16'h0400), enc_r(8, 8, 0, 0, 0)};
    load_prog();
    do_reset(2);
    run(4);
    check("oob_pc", dbg_pc, 32'h408);
    check("oob_instr", dbg_instr, 32'd0);

    // Random straight-line programs
    for (int r = 0; r < 3; r++) begin
      prog = {};
      for (int i = 0; i < 48; i++) prog.push_back(rand_instr());
      prog.push_back(enc_j(2, 48));
      load_prog();
      do_reset(2);
      run(52);
      compare_state("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
